// File: rtl/ssd_scan_driver.sv
// Multi-digit common-anode seven-segment scan driver with per-frame shadow
// buffering, anti-ghost dead time, optional hex glyphs and leading-zero blanking.
module ssd_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int HEX_MODE     = 0,
    parameter int LZ_BLANK     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_CYCLES - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pcnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   dp_shadow;

    logic                    wrap;
    logic                    reload;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_live;
    logic                    acc;
    logic [NUM_DIGITS-1:0]   sel;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        if (HEX_MODE == 0 && code > 4'h9) s = 7'b1111111;
        return s;
    endfunction

    assign wrap   = en && (pcnt == P_LAST);
    assign reload = wrap && (idx == I_LAST);

    // Walk from the top digit down so acc means "this digit or any above is non-zero".
    always_comb begin
        acc      = 1'b0;
        cur_code = 4'd0;
        cur_dp   = 1'b0;
        cur_live = 1'b1;
        sel      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            acc = acc | (shadow[4*k +: 4] != 4'd0);
            if (idx == IW'(k)) begin
                sel[k]   = 1'b1;
                cur_code = shadow[4*k +: 4];
                cur_dp   = dp_shadow[k];
                cur_live = acc || (k == 0);
            end
        end
        blank   = !en || (pcnt < P_BLANK) || ((LZ_BLANK != 0) && !cur_live);
        an_nxt  = '1;
        seg_nxt = 7'b1111111;
        dp_nxt  = 1'b1;
        if (!blank) begin
            an_nxt  = ~sel;
            seg_nxt = decode(cur_code);
            dp_nxt  = ~cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            idx        <= '0;
            shadow     <= '0;
            dp_shadow  <= '0;
            frame_done <= 1'b0;
            an         <= '1;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
        end else begin
            if (en) pcnt <= wrap ? '0 : pcnt + 1'b1;
            if (wrap) idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
            if (reload) begin
                shadow    <= value;
                dp_shadow <= dp_in;
            end
            frame_done <= reload;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
        end
    end

endmodule
